spi_master_arbiter: RTL and testbench

- Round-robin arbiter sharing one SPI_Master between NREQ firmware requesters, e.g. PCI register bridge, config loader and monitor poller.
- Latches the winning requester's 32-bit word and chip-select, then drives SPI_Master's start/data/select inputs.
- Waits for SPI_DONE, returns the 32-bit read word to the winner, and advances the priority pointer.
- Sits between the requesters and SPI_Master; it is the only driver of SPI_Master's SPI_START_I/SPI_I/SPI_SEL_I.

---
 rtl/spi_master_arbiter_pkg.sv | 18 +
 rtl/spi_master_arbiter_if.sv | 36 +++
 rtl/spi_master_arbiter_rr_pick.sv | 34 +++
 rtl/spi_master_arbiter.sv | 162 ++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_arbiter_pkg.sv
// Shared constants for the SPI master arbiter: FSM encoding, bus widths
// and the word returned when a transaction is forced closed.
package spi_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int SPI_WORD_W = 32;
    localparam int SPI_SEL_W  = 2;

    localparam logic [SPI_WORD_W-1:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

    typedef logic [SPI_WORD_W-1:0] spi_word_t;
    typedef logic [SPI_SEL_W-1:0]  spi_sel_t;

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester and SPI_Master side signals of the arbiter.
// master modport is the arbiter's view, slave is the environment's view.
interface spi_master_arbiter_if #(
    parameter int NREQ = 3
);
    import spi_arb_pkg::*;

    logic [NREQ-1:0]            REQ_I;
    logic [SPI_WORD_W*NREQ-1:0] REQ_DATA_I;
    logic [SPI_SEL_W*NREQ-1:0]  REQ_SEL_I;
    logic [NREQ-1:0]            GNT_O;
    logic [NREQ-1:0]            DONE_O;
    spi_word_t                  RDATA_O;
    logic                       ERR_O;
    logic                       BUSY_O;
    logic                       SPI_START_O;
    spi_word_t                  SPI_DATA_O;
    spi_sel_t                   SPI_SEL_O;
    spi_word_t                  SPI_DATA_I;
    logic                       SPI_DONE_I;

    modport master (
        input  REQ_I, REQ_DATA_I, REQ_SEL_I,
        input  SPI_DATA_I, SPI_DONE_I,
        output GNT_O, DONE_O, RDATA_O, ERR_O, BUSY_O,
        output SPI_START_O, SPI_DATA_O, SPI_SEL_O
    );

    modport slave (
        output REQ_I, REQ_DATA_I, REQ_SEL_I,
        output SPI_DATA_I, SPI_DONE_I,
        input  GNT_O, DONE_O, RDATA_O, ERR_O, BUSY_O,
        input  SPI_START_O, SPI_DATA_O, SPI_SEL_O
    );

endinterface

// File: rtl/spi_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from NREQ-1 back to 0.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx,
    output logic            win_valid
);

    logic [IW-1:0] j;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        j         = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = IW'((int'(ptr) + i) % NREQ);
            if (!win_valid && req[j]) begin
                win_valid  = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = j;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI_Master between NREQ requesters.
// Optional watchdog in WAIT_DONE enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int START_HOLD     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                BOARD_CLOCK,
    input  logic                RST,
    spi_master_arbiter_if.master bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NREQ - 1);

    logic [1:0]      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [HW-1:0]   hold_cnt;
    logic            spi_start;
    spi_word_t       spi_data;
    spi_sel_t        spi_sel;
    spi_word_t       rdata;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    spi_word_t       pick_data;
    spi_sel_t        pick_sel;
    logic [IW-1:0]   ptr_next;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req       (bus.REQ_I),
        .ptr       (ptr),
        .win_oh    (pick_oh),
        .win_idx   (pick_idx),
        .win_valid (pick_valid)
    );

    // Select the winning requester's word and chip-select fields.
    always_comb begin
        pick_data = '0;
        pick_sel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_oh[k]) begin
                pick_data = bus.REQ_DATA_I[k*SPI_WORD_W +: SPI_WORD_W];
                pick_sel  = bus.REQ_SEL_I[k*SPI_SEL_W +: SPI_SEL_W];
            end
        end
    end

    assign ptr_next = (gidx == IDX_LAST) ? '0 : gidx + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;
    logic        err;
    logic        to_hit;

    assign to_hit = (to_cnt == TO_LAST);
`endif

    // Main FSM: grant, hold start, wait for done, wait for done to drop.
    always_ff @(posedge BOARD_CLOCK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            gnt       <= '0;
            done      <= '0;
            hold_cnt  <= '0;
            spi_start <= 1'b0;
            spi_data  <= '0;
            spi_sel   <= '0;
            rdata     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            err       <= 1'b0;
`endif
        end else begin
            done <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err  <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt       <= pick_oh;
                        gidx      <= pick_idx;
                        spi_data  <= pick_data;
                        spi_sel   <= pick_sel;
                        spi_start <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (hold_cnt == HOLD_LAST) begin
                        spi_start <= 1'b0;
                        state     <= ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.SPI_DONE_I) begin
                        rdata <= bus.SPI_DATA_I;
                        done  <= gnt;
                        gnt   <= '0;
                        ptr   <= ptr_next;
                        state <= ST_RELEASE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        rdata <= TIMEOUT_FILL;
                        done  <= gnt;
                        err   <= 1'b1;
                        gnt   <= '0;
                        ptr   <= ptr_next;
                        state <= ST_RELEASE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (!bus.SPI_DONE_I) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.GNT_O       = gnt;
    assign bus.DONE_O      = done;
    assign bus.RDATA_O     = rdata;
    assign bus.BUSY_O      = (state != ST_IDLE);
    assign bus.SPI_START_O = spi_start;
    assign bus.SPI_DATA_O  = spi_data;
    assign bus.SPI_SEL_O   = spi_sel;
`ifdef SPI_ARB_TIMEOUT_EN
    assign bus.ERR_O       = err;
`else
    assign bus.ERR_O       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: table of single transactions
// plus hand-written round-robin, held-done, withdrawal and reset cases.
module tb_spi_master_arbiter;
    import spi_arb_pkg::*;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spi_master_arbiter_if #(.NREQ(N)) bus ();

    spi_master_arbiter #(
        .NREQ           (N),
        .START_HOLD     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .BOARD_CLOCK (clk),
        .RST         (rst_n),
        .bus         (bus)
    );

    typedef struct {
        logic [2:0]  req;
        int          idx;
        logic [31:0] data;
        logic [1:0]  sel;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_gnt(input string nm, input logic [2:0] exp);
        int n;
        n = 0;
        while (bus.GNT_O == '0 && n < 50) begin
            step();
            n++;
        end
        chk(nm, 32'(bus.GNT_O), 32'(exp));
        chk({nm, "_start"}, 32'(bus.SPI_START_O), 32'd1);
    endtask

    task automatic wait_start_low(output int n);
        n = 0;
        while (bus.SPI_START_O && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic finish(input string nm, input logic [31:0] rd,
                          input logic [2:0] exp_oh, input logic [1:0] exp_sel,
                          input logic drop);
        bus.SPI_DATA_I = rd;
        bus.SPI_DONE_I = 1'b1;
        step();
        chk({nm, "_done"}, 32'(bus.DONE_O), 32'(exp_oh));
        chk({nm, "_rdata"}, bus.RDATA_O, rd);
        chk({nm, "_gnt_clr"}, 32'(bus.GNT_O), 32'd0);
        chk({nm, "_err"}, 32'(bus.ERR_O), 32'd0);
        chk({nm, "_sel_hold"}, 32'(bus.SPI_SEL_O), 32'(exp_sel));
        if (drop) bus.REQ_I = '0;
        bus.SPI_DONE_I = 1'b0;
        bus.SPI_DATA_I = 32'h5A5A_5A5A;
        step();
        chk({nm, "_done_1cyc"}, 32'(bus.DONE_O), 32'd0);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [2:0] eg;
        string nm;
        int n;
        nm = $sformatf("vec%0d", i);
        eg = 3'b001 << v.idx;
        for (int k = 0; k < N; k++) begin
            bus.REQ_DATA_I[32*k +: 32] = ~v.data ^ 32'(k);
            bus.REQ_SEL_I[2*k +: 2]    = ~v.sel;
        end
        bus.REQ_DATA_I[32*v.idx +: 32] = v.data;
        bus.REQ_SEL_I[2*v.idx +: 2]    = v.sel;
        bus.REQ_I = v.req;
        step();
        chk({nm, "_gnt"}, 32'(bus.GNT_O), 32'(eg));
        chk({nm, "_start"}, 32'(bus.SPI_START_O), 32'd1);
        chk({nm, "_sel"}, 32'(bus.SPI_SEL_O), 32'(v.sel));
        chk({nm, "_data"}, bus.SPI_DATA_O, v.data);
        chk({nm, "_busy"}, 32'(bus.BUSY_O), 32'd1);
        wait_start_low(n);
        chk({nm, "_hold"}, 32'(n), 32'd4);
        bus.REQ_I = '0;
        chk({nm, "_gnt_held"}, 32'(bus.GNT_O), 32'(eg));
        step();
        step();
        finish(nm, v.rd, eg, v.sel, 1'b1);
        chk({nm, "_idle"}, 32'(bus.BUSY_O), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        logic [2:0] exp_g;

        vt[0] = '{3'b001, 0, 32'hCCCC_CCCE, 2'd2, 32'h1234_5678};
        vt[1] = '{3'b101, 2, 32'hA5A5_0001, 2'd1, 32'h8765_4321};
        vt[2] = '{3'b110, 1, 32'h0000_0000, 2'd3, 32'hFFFF_0000};
        vt[3] = '{3'b011, 0, 32'hFFFF_FFFF, 2'd0, 32'h0000_0001};
        vt[4] = '{3'b001, 0, 32'h1357_9BDF, 2'd1, 32'hDEAD_BEEF};
        vt[5] = '{3'b100, 2, 32'h8000_0001, 2'd2, 32'h5555_AAAA};

        bus.REQ_I      = '0;
        bus.REQ_DATA_I = '0;
        bus.REQ_SEL_I  = '0;
        bus.SPI_DATA_I = '0;
        bus.SPI_DONE_I = 1'b0;

        step();
        step();
        chk("rst_gnt", 32'(bus.GNT_O), 32'd0);
        chk("rst_done", 32'(bus.DONE_O), 32'd0);
        chk("rst_err", 32'(bus.ERR_O), 32'd0);
        chk("rst_busy", 32'(bus.BUSY_O), 32'd0);
        chk("rst_start", 32'(bus.SPI_START_O), 32'd0);
        chk("rst_data", bus.SPI_DATA_O, 32'd0);
        chk("rst_sel", 32'(bus.SPI_SEL_O), 32'd0);
        chk("rst_rdata", bus.RDATA_O, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

        // all three requesting: pointer is back at 0
        bus.REQ_DATA_I = {32'hC2, 32'hC1, 32'hC0};
        bus.REQ_SEL_I  = 6'b11_01_10;
        bus.REQ_I      = 3'b111;
        for (int g = 0; g < 4; g++) begin
            int k;
            logic [1:0] es;
            k = g % 3;
            es = (k == 0) ? 2'd2 : (k == 1) ? 2'd1 : 2'd3;
            exp_g = 3'b001 << k;
            wait_gnt($sformatf("rr%0d_gnt", g), exp_g);
            chk($sformatf("rr%0d_data", g), bus.SPI_DATA_O, 32'hC0 + 32'(k));
            wait_start_low(n);
            finish($sformatf("rr%0d", g), 32'h100 + 32'(g), exp_g, es,
                   g == 3);
        end

        // level-held done with requester 1 pending
        bus.REQ_I = 3'b001;
        wait_gnt("lvl_gnt0", 3'b001);
        bus.REQ_I = 3'b010;
        wait_start_low(n);
        bus.SPI_DATA_I = 32'h0BAD_F00D;
        bus.SPI_DONE_I = 1'b1;
        step();
        chk("lvl_done0", 32'(bus.DONE_O), 32'b001);
        chk("lvl_rdata0", bus.RDATA_O, 32'h0BAD_F00D);
        cnt = 0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.DONE_O != '0) cnt++;
            if (bus.GNT_O != '0) n++;
        end
        chk("lvl_no_done", 32'(cnt), 32'd0);
        chk("lvl_no_gnt", 32'(n), 32'd0);
        chk("lvl_busy", 32'(bus.BUSY_O), 32'd1);
        bus.SPI_DONE_I = 1'b0;
        wait_gnt("lvl_gnt1", 3'b010);
        wait_start_low(n);
        finish("lvl1", 32'h7777_0001, 3'b010, 2'd1, 1'b1);

        // withdrawal: requester 2 pulses while 0 is granted
        bus.REQ_I = 3'b001;
        wait_gnt("wd_gnt", 3'b001);
        bus.REQ_I = 3'b101;
        step();
        bus.REQ_I = 3'b001;
        wait_start_low(n);
        finish("wd", 32'h2222_3333, 3'b001, 2'd2, 1'b1);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.GNT_O != '0) n++;
        end
        chk("wd_never", 32'(n), 32'd0);
        chk("wd_idle", 32'(bus.BUSY_O), 32'd0);

        // reset in WAIT_DONE
        bus.REQ_I = 3'b010;
        wait_gnt("rs_gnt", 3'b010);
        bus.REQ_I = '0;
        wait_start_low(n);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_gnt0", 32'(bus.GNT_O), 32'd0);
        chk("rs_busy0", 32'(bus.BUSY_O), 32'd0);
        chk("rs_data0", bus.SPI_DATA_O, 32'd0);
        chk("rs_sel0", 32'(bus.SPI_SEL_O), 32'd0);
        chk("rs_rdata0", bus.RDATA_O, 32'd0);
        chk("rs_done0", 32'(bus.DONE_O), 32'd0);
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.DONE_O != '0) cnt++;
        end
        chk("rs_no_done", 32'(cnt), 32'd0);
        bus.REQ_I = 3'b011;
        wait_gnt("rs_next", 3'b001);
        bus.REQ_I = '0;
        wait_start_low(n);
        finish("rs", 32'h4444_5555, 3'b001, 2'd2, 1'b1);

`ifdef SPI_ARB_TIMEOUT_EN
        bus.REQ_I = 3'b001;
        wait_gnt("to_gnt", 3'b001);
        bus.REQ_I = '0;
        wait_start_low(n);
        n = 0;
        while (bus.DONE_O == '0 && n < 100) begin
            step();
            n++;
        end
        chk("to_lat", 32'(n), 32'd16);
        chk("to_done", 32'(bus.DONE_O), 32'b001);
        chk("to_err", 32'(bus.ERR_O), 32'd1);
        chk("to_rdata", bus.RDATA_O, 32'hFFFF_FFFF);
        step();
        chk("to_err_clr", 32'(bus.ERR_O), 32'd0);
        chk("to_done_clr", 32'(bus.DONE_O), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
